multiplier_nbit: RTL
====================

MULTIPLIER_NBIT -- requirements
Module: multiplier_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port Clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port ClearA_LoadB  input  1  clear A/X, load S into B; honoured only in READY.
REQ-006 SHALL have port Run  input  1  level start request; one multiply per low-to-high episode.
REQ-007 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at start, held internally.
REQ-008 SHALL have port S  input  WIDTH  multiplicand at Run; multiplier value at ClearA_LoadB.
REQ-009 SHALL have port Aval  output  WIDTH  register A, upper half of the product.
REQ-010 SHALL have port Bval  output  WIDTH  register B, lower half of the product.
REQ-011 SHALL have port X  output  1  sign/carry extension bit.
REQ-012 SHALL have port M  output  1  equals B[0].
REQ-013 SHALL have port Busy  output  1  high in ADD and SHIFT.
REQ-014 SHALL have port Done  output  1  high in DONE only.

Function
REQ-015 SHALL implement FSM states READY, LOAD, ADD, SHIFT, DONE; all registers are updated only on rising Clk.
REQ-016 READY: Run=1 -> ADD; else ClearA_LoadB=1 -> LOAD; else hold. Run has priority over ClearA_LoadB.
REQ-017 Start (READY->ADD edge): A<=0, X<=0, iteration counter<=0, mode<=Signed; B is unchanged; S must be held stable until Done.
REQ-018 LOAD: A<=0, X<=0, B<=S; always -> READY next cycle.
REQ-019 ADD: fixed single cycle every iteration (adds 0 when M=0), so timing is data-independent; -> SHIFT.
REQ-020 ADD arithmetic, WIDTH+1 bits: signed: {A[W-1],A} +/- {S[W-1],S}, subtract only on last iteration (counter=WIDTH-1); unsigned: {0,A}+{0,S}; result bit WIDTH -> X, low bits -> A; only when M=1.
REQ-021 SHIFT: {X,A,B} <= {X,A,B} >> 1; new X = old X if signed, 0 if unsigned; counter increments; counter==WIDTH-1 before increment -> DONE, else -> ADD.
REQ-022 Counter width SHALL be $clog2(WIDTH)+1 bits; no wrap occurs within a multiply.
REQ-023 Latency: Done SHALL rise 2*WIDTH cycles after the start edge, i.e. first DONE cycle begins at start edge + 2*WIDTH.
REQ-024 Result {Aval,Bval} SHALL equal the exact 2*WIDTH-bit product (signed or unsigned per mode), including S = B = most-negative.
REQ-025 DONE: hold A, B, X; Run=0 -> READY; Run held high SHALL NOT restart.
REQ-026 ClearA_LoadB and Signed changes during ADD/SHIFT/DONE SHALL be ignored.
REQ-027 Back-to-back: B retains the product low half, so a new Run without LOAD multiplies S by the previous Bval.

Reset
REQ-028 Reset=1 at a rising edge, in any state including mid-multiply: state<=READY, A=0, B=0, X=0, counter=0, Busy=0, Done=0, M=0, next cycle.
REQ-029 Reset SHALL override Run and ClearA_LoadB in the same cycle; the FSM SHALL NOT leave READY while Reset=1.

Verification
REQ-030 WIDTH=8, Signed=1: LOAD S=0xFD, Run with S=0x07 -> Done at start+16, {Aval,Bval}=0xFFEB, X=1.
REQ-031 WIDTH=8, Signed=0: LOAD 0xFD, Run S=0x07 -> {Aval,Bval}=0x06EB, X=0.
REQ-032 WIDTH=8, Signed=1: LOAD 0x80, Run S=0x80 -> 0x4000; LOAD 0x80, S=0x7F -> 0xC080.
REQ-033 WIDTH=16, Signed=1: LOAD 0x7FFF, Run S=0x7FFF -> 0x3FFF0001, Done exactly 32 cycles after start.
REQ-034 Reset pulsed at start+5 -> next cycle all outputs 0, READY; Run still high restarts at next edge after Reset falls.
REQ-035 Run held high 10 cycles past Done -> no restart, outputs stable; ClearA_LoadB pulsed mid-multiply -> no effect on result.

Source files
------------

// File: rtl/multiplier_nbit.sv
// Sequential add-shift WIDTHxWIDTH multiplier (signed or unsigned); Done rises 2*WIDTH cycles after Run starts it.
// No backpressure: Run is a level request, and Done holds until Run drops.
module multiplier_nbit #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ClearA_LoadB,
   input  logic             Run,
   input  logic             Signed,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             M,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {READY, LOAD, ADD, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a, a_n, b, b_n;
   logic             x, x_n, mode, mode_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             last;
   logic [WIDTH:0]   a_ext, addend, sum;

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= READY;
         a     <= '0;
         b     <= '0;
         x     <= 1'b0;
         cnt   <= '0;
         mode  <= 1'b0;
      end else begin
         state <= state_n;
         a     <= a_n;
         b     <= b_n;
         x     <= x_n;
         cnt   <= cnt_n;
         mode  <= mode_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a;
      b_n     = b;
      x_n     = x;
      cnt_n   = cnt;
      mode_n  = mode;
      Busy    = 1'b0;
      Done    = 1'b0;
      // Last signed iteration weighs the multiplier sign bit negatively, hence the subtract.
      addend  = mode ? {S[WIDTH-1], S} : {1'b0, S};
      a_ext   = mode ? {a[WIDTH-1], a} : {1'b0, a};
      sum     = (mode && last) ? (a_ext - addend) : (a_ext + addend);
      case (state)
         READY: begin
            if (Run) begin
               state_n = ADD;
               a_n     = '0;
               x_n     = 1'b0;
               cnt_n   = '0;
               mode_n  = Signed;
            end else if (ClearA_LoadB) begin
               state_n = LOAD;
            end
         end
         LOAD: begin
            a_n     = '0;
            x_n     = 1'b0;
            b_n     = S;
            state_n = READY;
         end
         ADD: begin
            Busy = 1'b1;
            if (b[0]) begin
               x_n = sum[WIDTH];
               a_n = sum[WIDTH-1:0];
            end
            state_n = SHIFT;
         end
         SHIFT: begin
            Busy    = 1'b1;
            x_n     = mode ? x : 1'b0;
            a_n     = {x, a[WIDTH-1:1]};
            b_n     = {a[0], b[WIDTH-1:1]};
            cnt_n   = cnt + CW'(1);
            state_n = last ? DONE : ADD;
         end
         DONE: begin
            Done = 1'b1;
            if (!Run) state_n = READY;
         end
         default: state_n = READY;
      endcase
   end

   assign Aval = a;
   assign Bval = b;
   assign X    = x;
   assign M    = b[0];

endmodule
